// File: rtl/fifo_ctrl_fft.sv
// fifo_ctrl_fft: pointer/sequencing controller for the FFT sample-buffer RAM with a registered FWFT output stage.
// Watermark flags are built only when FIFO_CTRL_FFT_WMARK_EN is defined; otherwise they are tied low.
module fifo_ctrl_fft #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int AFULL_TH   = 12,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

   out_state_t          state, state_next;
   logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, ram_cnt;
   logic                ram_full, ram_empty, wr_fire, load, load_data;

   assign ram_cnt   = wr_ptr - rd_ptr;
   assign ram_full  = (ram_cnt == DEPTH);
   assign ram_empty = (ram_cnt == PTR_ZERO);
   assign m_valid   = (state == OUT_FULL);

   assign s_ready = !ram_full && !rst && !flush;
   assign wr_fire = s_valid && s_ready;
   assign load    = !ram_empty && (!m_valid || m_ready);

   assign ram_wr_en   = wr_fire;
   assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_wr_data = s_data;
   assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

   assign level = ram_cnt + {{ADDR_WIDTH{1'b0}}, m_valid};

   // Next-state for pointers and output stage; flush overrides everything except m_data
   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      state_next  = state;
      load_data   = 1'b0;
      if (flush) begin
         wr_ptr_next = PTR_ZERO;
         rd_ptr_next = PTR_ZERO;
         state_next  = OUT_EMPTY;
      end else begin
         if (wr_fire) begin
            wr_ptr_next = wr_ptr + PTR_ONE;
         end else begin
            wr_ptr_next = wr_ptr;
         end
         if (load) begin
            rd_ptr_next = rd_ptr + PTR_ONE;
            load_data   = 1'b1;
         end else begin
            rd_ptr_next = rd_ptr;
         end
         case (state)
            OUT_EMPTY: begin
               if (load) state_next = OUT_FULL;
               else      state_next = OUT_EMPTY;
            end
            OUT_FULL: begin
               if (load)         state_next = OUT_FULL;
               else if (m_ready) state_next = OUT_EMPTY;
               else              state_next = OUT_FULL;
            end
            default: state_next = OUT_EMPTY;
         endcase
      end
   end

   // Pointer and output-stage state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= PTR_ZERO;
         rd_ptr <= PTR_ZERO;
         state  <= OUT_EMPTY;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         state  <= state_next;
      end
   end

   // Output data register: captures the asynchronous RAM read on load, holds through flush
   always_ff @(posedge clk) begin
      if (rst) begin
         m_data <= {DATA_WIDTH{1'b0}};
      end else if (load_data) begin
         m_data <= ram_rd_data;
      end else begin
         m_data <= m_data;
      end
   end

`ifdef FIFO_CTRL_FFT_WMARK_EN
   localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_TH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_TH);

   logic [ADDR_WIDTH:0] level_next;

   assign level_next = (wr_ptr_next - rd_ptr_next) +
                       {{ADDR_WIDTH{1'b0}}, (state_next == OUT_FULL)};

   // Flags use the post-edge level so they line up with level in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b0;
      end else begin
         almost_full  <= (level_next >= AFULL_LVL);
         almost_empty <= (level_next <= AEMPTY_LVL);
      end
   end
`else
   assign almost_full  = 1'b0;
   assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_fft.sv
// tb_fifo_ctrl_fft: directed and randomized checks of fifo_ctrl_fft against a queue-based occupancy model.
// Watermark expectations follow FIFO_CTRL_FFT_WMARK_EN when the bench is built with it.
module tb_fifo_ctrl_fft;

   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst, flush, s_valid, m_ready;
   logic [DW-1:0] s_data;
   logic          s_ready, m_valid, almost_full, almost_empty, ram_wr_en;
   logic [DW-1:0] m_data, ram_wr_data, ram_rd_data;
   logic [AW:0]   level;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;

   logic [DW-1:0] mem [16];

   int total = 0;
   int bad   = 0;
   int n_acc = 0;

   logic [DW-1:0] q [$];
   logic          mv = 1'b0;
   logic          af = 1'b0;
   logic          ae = 1'b0;

   fifo_ctrl_fft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
      .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   // Simple-dual-port RAM with asynchronous read
   always_ff @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
   end
   assign ram_rd_data = mem[ram_rd_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the model, take the edge, then advance the model.
   task automatic cycle();
      int   held, old, p;
      logic exp_sr;
      #1;
      held   = q.size() - (mv ? 1 : 0);
      exp_sr = !rst && !flush && (held < 16);
      chk("s_ready", s_ready, exp_sr);
      chk("ram_wr_en", ram_wr_en, s_valid && exp_sr);
      chk("m_valid", m_valid, mv);
      chk("level", level, q.size());
      if (mv) chk("m_data", m_data, q[0]);
      chk("almost_full", almost_full, af);
      chk("almost_empty", almost_empty, ae);
      chk("level_cap", level <= 17, 1'b1);
      @(posedge clk);
      if (rst || flush) begin
         q.delete();
         mv = 1'b0;
      end else begin
         old = q.size();
         p   = (mv && m_ready) ? 1 : 0;
         if (p == 1) void'(q.pop_front());
         if (s_valid && exp_sr) begin
            q.push_back(s_data);
            n_acc++;
         end
         mv = (old - p) > 0;
      end
`ifdef FIFO_CTRL_FFT_WMARK_EN
      af = !rst && (q.size() >= 14);
      ae = !rst && (q.size() <= 2);
`else
      af = 1'b0;
      ae = 1'b0;
`endif
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; s_valid = 1'b1; m_ready = 1'b0; s_data = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);

      // Reset held three cycles with a pending write
      for (int i = 0; i < 3; i++) cycle();
      chk("reset_m_data", m_data, 32'h0);
      rst = 1'b0; s_valid = 1'b0;
      #1 chk("s_ready_after_reset", s_ready, 1'b1);
      cycle();

      // Fill with m_ready low: 17 accepted, the 18th refused
      m_ready = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         s_valid = 1'b1; s_data = DW'(i);
         if (i == 18) begin
            #1;
            chk("fill_level", level, 17);
            chk("fill_m_data", m_data, 32'h01);
            chk("fill_m_valid", m_valid, 1'b1);
            chk("fill_s_ready", s_ready, 1'b0);
         end
         cycle();
      end

      // Drain
      s_valid = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 18; i++) cycle();
      chk("drain_level", level, 0);
      chk("drain_m_valid", m_valid, 1'b0);

      // Continuous stream
      for (int i = 0; i < 100; i++) begin
         s_valid = 1'b1; m_ready = 1'b1; s_data = 32'h100 + DW'(i);
         if (i >= 2) chk("stream_level", level, 2);
         cycle();
      end
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) cycle();

      // Flush with a write pending, then a fresh word
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_data = 32'h500 + DW'(i);
         cycle();
      end
      flush = 1'b1; s_data = 32'hBB;
      cycle();
      flush = 1'b0; s_valid = 1'b0;
      chk("flush_level", level, 0);
      chk("flush_m_valid", m_valid, 1'b0);
      chk("flush_m_data_hold", m_data, 32'h500);
      s_valid = 1'b1; s_data = 32'hAA;
      cycle();
      s_valid = 1'b0;
      cycle();
      chk("post_flush_m_valid", m_valid, 1'b1);
      chk("post_flush_m_data", m_data, 32'hAA);
      m_ready = 1'b1;
      cycle();
      chk("post_flush_empty", level, 0);

      // Randomized traffic across many wraps
      n_acc = 0;
      for (int c = 0; c < 6000 && n_acc < 200; c++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         m_ready = (c % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
         s_data  = $urandom;
         cycle();
      end
      chk("rand_accepted", n_acc, 200);
      s_valid = 1'b0; m_ready = 1'b1;
      for (int c = 0; c < 40 && q.size() != 0; c++) cycle();
      cycle();
      chk("rand_drained", level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
